reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Parametrised multi-read-port register file with a per-register pending-write scoreboard, for the ID stage.
//  Decode reads NUM_RD operands per cycle and sees whether each operand is still awaited from a writeback.
//  Decode reserves a destination register at issue time, and writeback releases it.
//  Register 0 is optionally hardwired to zero.
// PARAMETERS
//  DATA_W    32  register width in bits
//  ADDR_W    5   address width; depth = 2**ADDR_W
//  NUM_RD    2   number of read ports (1..4)
//  ZERO_REG  1   1: reg 0 always reads 0, ignores writes, is never busy; 0: reg 0 is ordinary
// PORTS
//  clk             in   1              clock; all state updates on posedge
//  rst             in   1              synchronous reset, active-high
//  reg_addr        in   NUM_RD*ADDR_W  read addresses; port i = [i*ADDR_W +: ADDR_W]
//  reg_out         out  NUM_RD*DATA_W  read data; port i = [i*DATA_W +: DATA_W]
//  reg_busy        out  NUM_RD         1 = register addressed by port i has a pending write
//  reg_wr          in   1              writeback enable
//  reg_write_addr  in   ADDR_W         writeback address
//  reg_din         in   DATA_W         writeback data
//  reg_issue       in   1              request to reserve reg_issue_addr as a pending destination
//  reg_issue_addr  in   ADDR_W         destination to reserve
//  reg_issue_ok    out  1              request accepted this cycle (handshake)
//  reg_pend_cnt    out  ADDR_W+1       number of registers currently busy (registered)
// BEHAVIOUR
//  - Reset (clk edge with rst=1): every register is set to 0. Every busy bit is cleared. reg_pend_cnt becomes 0.
//    Issue and write inputs in the reset cycle are ignored.
//    Therefore after reset: reg_out = 0, reg_busy = 0, reg_issue_ok = reg_issue.
//  - Reads are combinational from the array, with zero latency.
//  - Write: on posedge with reg_wr=1, mem[reg_write_addr] <= reg_din. The new value is visible the cycle after.
//    With ZERO_REG=1 and address 0, the write is dropped.
//  - Scoreboard handshake: reg_issue_ok = reg_issue & ~busy[reg_issue_addr] (combinational).
//    An accepted issue sets busy[reg_issue_addr] at the next edge.
//    If the issue is refused, decode holds reg_issue/reg_issue_addr stable and retries.
//    With ZERO_REG=1, an issue to reg 0 is always accepted and sets no bit.
//  - reg_wr=1 clears busy[reg_write_addr] at the edge.
//    A write to a non-busy register is legal and leaves the bit at 0.
//  - Same cycle, same address, accepted issue + write: the issue wins. Data is written and busy ends at 1.
//  - Same cycle, different addresses: both take effect independently.
//  - reg_pend_cnt tracks busy-bit transitions: +1 on a set, -1 on a clear, and no change when a set and a clear both occur.
//    It cannot exceed 2**ADDR_W (2**ADDR_W-1 with ZERO_REG=1).
// CONFIGURATION
//  REG_FILE_BYPASS_EN defined: a read port whose address equals reg_write_addr while reg_wr=1 (non-zero reg when ZERO_REG=1)
//    returns reg_din and reports reg_busy=0 in the same cycle. This is write-through forwarding.
//  Not defined: that port returns the old array value and the current busy bit until the edge.
// STRUCTURE
//  Package reg_file_pkg: DATA_W/ADDR_W defaults, reg_addr_t, reg_data_t, ZERO_ADDR constant.
//  Sub-module reg_file_scoreboard: busy vector, issue handshake, reg_pend_cnt.
//  The top level keeps the storage array, read muxes and bypass.
// TESTING
//  1 Reset, then read all ports at addrs 0..3 -> reg_out=0, reg_busy=0, reg_pend_cnt=0.
//  2 Write reg2=0x000000F0, then reg4=0x0000000F; read addr1=2, addr2=4 next cycle -> 0xF0 and 0x0F.
//  3 Issue reg5 -> ok=1, then busy=1 and cnt=1. Re-issue reg5 -> ok=0.
//    Write reg5=0xAA -> busy=0, cnt=0, data=0xAA.
//  4 Issue reg7 and write reg7=0x55 in the same cycle -> reg7=0x55, busy=1, cnt=1.
//    Write reg3 with issue reg9 in the same cycle -> cnt unchanged by the reg3 write (reg3 not busy), cnt+1 from reg9.
//  5 ZERO_REG=1: write reg0=0xFFFFFFFF and issue reg0 -> reg_out=0, busy=0, ok=1, cnt unchanged.
//  6 Write reg6=0x1234 while reading addr 6 -> 0x1234 with busy=0 if REG_FILE_BYPASS_EN, else the old value.
//    Assert rst with 3 regs busy -> all state cleared next cycle.

Source files
------------

// File: rtl/reg_file_pkg.sv
// Shared types and constants for the ID-stage register file with pending-write scoreboard.
// Build option: REG_FILE_BYPASS_EN enables write-through forwarding on the read ports.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO_ADDR = '0;

  // How the pending counter moves on the next edge.
  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Per-register busy bits, issue handshake and registered count of pending writes.
// An accepted issue and a writeback on the same register resolve in favour of the issue.
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     issue,
  input  logic [ADDR_W-1:0]        issue_addr,
  output logic                     issue_ok,
  input  logic                     wr,
  input  logic [ADDR_W-1:0]        write_addr,
  output logic [(1<<ADDR_W)-1:0]   busy,
  output logic [ADDR_W:0]          pend_cnt
);

  logic                   set_en;
  logic                   clr_en;
  logic [(1<<ADDR_W)-1:0] busy_nxt;
  cnt_op_e                cnt_op;

  // NOTE: combinational blocks use blocking assignments and give every output a default first, so no latch is inferred.
  always_comb begin
    issue_ok = issue & ~busy[issue_addr];
    set_en   = issue_ok && !((ZERO_REG != 0) && (issue_addr == ADDR_W'(ZERO_ADDR)));
    clr_en   = wr && busy[write_addr];
    busy_nxt = busy;
    if (clr_en) busy_nxt[write_addr] = 1'b0;
    if (set_en) busy_nxt[issue_addr] = 1'b1;
    cnt_op = CNT_HOLD;
    if (set_en && !clr_en)      cnt_op = CNT_INC;
    else if (clr_en && !set_en) cnt_op = CNT_DEC;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      unique case (cnt_op)
        CNT_INC: pend_cnt <= pend_cnt + (ADDR_W+1)'(1);
        CNT_DEC: pend_cnt <= pend_cnt - (ADDR_W+1)'(1);
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with pending-write scoreboard for the ID stage.
// Build option: REG_FILE_BYPASS_EN forwards reg_din to matching read ports during a writeback.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD*ADDR_W-1:0] reg_addr,
  output logic [NUM_RD*DATA_W-1:0] reg_out,
  output logic [NUM_RD-1:0]        reg_busy,
  input  logic                     reg_wr,
  input  logic [ADDR_W-1:0]        reg_write_addr,
  input  logic [DATA_W-1:0]        reg_din,
  input  logic                     reg_issue,
  input  logic [ADDR_W-1:0]        reg_issue_addr,
  output logic                     reg_issue_ok,
  output logic [ADDR_W:0]          reg_pend_cnt
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic              wr_en;

  assign wr_en = reg_wr && !((ZERO_REG != 0) && (reg_write_addr == ADDR_W'(ZERO_ADDR)));

  // NOTE: the array is reset explicitly because reads after reset must return zero, which rules out a plain RAM macro.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[reg_write_addr] <= reg_din;
    end
  end

  reg_file_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .issue      (reg_issue),
    .issue_addr (reg_issue_addr),
    .issue_ok   (reg_issue_ok),
    .wr         (reg_wr),
    .write_addr (reg_write_addr),
    .busy       (busy),
    .pend_cnt   (reg_pend_cnt)
  );

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              fwd;

    assign addr    = reg_addr[p*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (addr == ADDR_W'(ZERO_ADDR));
`ifdef REG_FILE_BYPASS_EN
    // wr_en already excludes reg 0 when it is hardwired, so it is never forwarded.
    assign fwd = wr_en && (addr == reg_write_addr);
`else
    assign fwd = 1'b0;
`endif
    assign reg_out[p*DATA_W +: DATA_W] = fwd ? reg_din : (is_zero ? '0 : mem[addr]);
    assign reg_busy[p]                 = busy[addr] & ~fwd;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: directed steps then random traffic against an array model.
// Expected read results follow REG_FILE_BYPASS_EN when the bench is built with it.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int DW    = DEF_DATA_W;
  localparam int AW    = DEF_ADDR_W;
  localparam int NR    = 2;
  localparam int DEPTH = 1 << AW;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR*AW-1:0] reg_addr;
  logic [NR*DW-1:0] reg_out;
  logic [NR-1:0]    reg_busy;
  logic             reg_wr;
  logic [AW-1:0]    reg_write_addr;
  logic [DW-1:0]    reg_din;
  logic             reg_issue;
  logic [AW-1:0]    reg_issue_addr;
  logic             reg_issue_ok;
  logic [AW:0]      reg_pend_cnt;

  int tests = 0;
  int fails = 0;

  // Reference model: plain register contents and a set of awaited registers.
  logic [DW-1:0] m_mem  [DEPTH];
  bit            m_busy [DEPTH];

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .reg_addr       (reg_addr),
    .reg_out        (reg_out),
    .reg_busy       (reg_busy),
    .reg_wr         (reg_wr),
    .reg_write_addr (reg_write_addr),
    .reg_din        (reg_din),
    .reg_issue      (reg_issue),
    .reg_issue_addr (reg_issue_addr),
    .reg_issue_ok   (reg_issue_ok),
    .reg_pend_cnt   (reg_pend_cnt)
  );

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic bit m_fwd(input int a);
`ifdef REG_FILE_BYPASS_EN
    return reg_wr && (a == int'(reg_write_addr)) && (a != 0);
`else
    return 1'b0;
`endif
  endfunction

  // Compare every output against what the model says for the inputs now applied.
  task automatic check_all(input string step);
    for (int p = 0; p < NR; p++) begin
      int            a;
      logic [DW-1:0] exp_d;
      bit            exp_b;
      a     = int'(reg_addr[p*AW +: AW]);
      exp_d = (a == 0) ? '0 : m_mem[a];
      exp_b = m_busy[a];
      if (m_fwd(a)) begin
        exp_d = reg_din;
        exp_b = 1'b0;
      end
      check($sformatf("%s out%0d", step, p), reg_out[p*DW +: DW], exp_d);
      check($sformatf("%s busy%0d", step, p), DW'(reg_busy[p]), DW'(exp_b));
    end
    check({step, " issue_ok"}, DW'(reg_issue_ok),
          DW'(reg_issue && !m_busy[int'(reg_issue_addr)]));
    check({step, " pend_cnt"}, DW'(reg_pend_cnt), DW'(m_count()));
  endtask

  task automatic drive(input int a0, input int a1, input logic w, input int wa,
                       input logic [DW-1:0] d, input logic iss, input int ia);
    reg_addr       = {AW'(a1), AW'(a0)};
    reg_wr         = w;
    reg_write_addr = AW'(wa);
    reg_din        = d;
    reg_issue      = iss;
    reg_issue_addr = AW'(ia);
    #1;
  endtask

  // Advance one edge and apply the same edge to the model from the held inputs.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      bit ok;
      int wa, ia;
      wa = int'(reg_write_addr);
      ia = int'(reg_issue_addr);
      ok = reg_issue && !m_busy[ia];
      if (reg_wr && wa != 0) m_mem[wa] = reg_din;
      if (reg_wr) m_busy[wa] = 1'b0;
      if (ok && ia != 0) m_busy[ia] = 1'b1;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 1, 1'b1, 3, 32'hDEAD_BEEF, 1'b1, 4);
    tick();
    rst = 1'b0;

    drive(0, 1, 1'b0, 0, '0, 1'b0, 0);
    check_all("t1 rd01");
    drive(2, 3, 1'b0, 0, '0, 1'b0, 0);
    check_all("t1 rd23");
    check("t1 cnt", DW'(reg_pend_cnt), '0);

    drive(0, 0, 1'b1, 2, 32'h0000_00F0, 1'b0, 0);
    tick();
    drive(0, 0, 1'b1, 4, 32'h0000_000F, 1'b0, 0);
    tick();
    drive(2, 4, 1'b0, 0, '0, 1'b0, 0);
    check_all("t2 rd");
    check("t2 reg2", reg_out[0 +: DW], 32'h0000_00F0);
    check("t2 reg4", reg_out[DW +: DW], 32'h0000_000F);

    drive(5, 0, 1'b0, 0, '0, 1'b1, 5);
    check("t3 ok", DW'(reg_issue_ok), 1);
    tick();
    drive(5, 0, 1'b0, 0, '0, 1'b1, 5);
    check_all("t3 reissue");
    check("t3 refused", DW'(reg_issue_ok), 0);
    check("t3 cnt1", DW'(reg_pend_cnt), 1);
    tick();
    drive(1, 1, 1'b1, 5, 32'h0000_00AA, 1'b0, 0);
    tick();
    drive(5, 0, 1'b0, 0, '0, 1'b0, 0);
    check_all("t3 release");
    check("t3 cnt0", DW'(reg_pend_cnt), 0);

    drive(0, 0, 1'b1, 7, 32'h0000_0055, 1'b1, 7);
    tick();
    drive(7, 9, 1'b0, 0, '0, 1'b0, 0);
    check_all("t4 same");
    check("t4 reg7", reg_out[0 +: DW], 32'h0000_0055);
    drive(3, 9, 1'b1, 3, 32'h0000_0033, 1'b1, 9);
    tick();
    drive(3, 9, 1'b0, 0, '0, 1'b0, 0);
    check_all("t4 diff");
    check("t4 cnt2", DW'(reg_pend_cnt), 2);

    drive(0, 0, 1'b1, 0, 32'hFFFF_FFFF, 1'b1, 0);
    check_all("t5 pre");
    tick();
    drive(0, 0, 1'b0, 0, '0, 1'b0, 0);
    check_all("t5 zero");

    drive(6, 2, 1'b1, 6, 32'h0000_1234, 1'b0, 0);
    check_all("t6 bypass");
    tick();
    drive(6, 0, 1'b0, 0, '0, 1'b1, 10);
    check_all("t6 written");
    tick();
    check("t6 cnt3", DW'(reg_pend_cnt), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(7, 10, 1'b0, 0, '0, 1'b0, 0);
    check_all("t6 reset");

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 7), $urandom_range(0, DEPTH-1), 1'($urandom_range(0, 1)),
            $urandom_range(0, 7), $urandom(), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      if (!rst) check_all($sformatf("rnd%0d", n));
      tick();
    end
    rst = 1'b0;
    drive(1, 2, 1'b0, 0, '0, 1'b0, 0);
    check_all("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
